// File: rtl/dmem_bus_master.sv
// dmem_bus_master: turns one MEM-stage load/store into a single DAD/DDT bus transaction,
// stalling the pipeline until ACKD_n and reporting misaligned, illegal-size and timed-out accesses.
module dmem_bus_master #(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 stall,
  output logic                 resp_valid,
  output logic [BIT_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic [1:0]           resp_code,
  output logic [BIT_WIDTH-1:0] DAD,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  inout  wire  [BIT_WIDTH-1:0] DDT,
  input  logic                 ACKD_n
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t               r_state;
  logic [BIT_WIDTH-1:0] r_addr, r_wdata, r_rdata;
  logic [1:0]           r_size, r_code;
  logic                 r_write, r_signed, r_valid, r_err;
  logic [31:0]          r_cnt;
  logic                 w_mis, w_ill, w_legal, w_req, w_to;
  logic [BIT_WIDTH-1:0] w_ext;
  assign w_mis   = req_size == 2'b00 ? req_addr[1:0] != 2'b00 : req_size == 2'b01 && req_addr[0];
  assign w_ill   = req_size == 2'b11;
  assign w_legal = !w_mis && !w_ill;
  assign w_req   = r_state == REQ;
  // abort on the TIMEOUT-th edge in REQ without an acknowledge
  assign w_to    = TIMEOUT != 0 && r_cnt == 32'(TIMEOUT - 1);
  assign w_ext   = r_size == 2'b01 ? {{(BIT_WIDTH-16){r_signed & DDT[15]}}, DDT[15:0]}
                 : r_size == 2'b10 ? {{(BIT_WIDTH-8){r_signed & DDT[7]}}, DDT[7:0]} : DDT;
  assign stall      = (r_state == IDLE && req_valid && w_legal) || w_req;
  assign resp_valid = r_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign resp_code  = r_code;
  assign DAD        = r_addr;
  assign MREQ       = w_req;
  assign WRITE      = r_write;
  assign SIZE       = r_size;
  assign DDT        = (w_req && r_write) ? r_wdata : 'z;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_size   <= 2'b00;
      r_code   <= 2'b00;
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == IDLE) begin
        if (req_valid && w_legal) begin
          r_state  <= REQ;
          r_addr   <= req_addr;
          r_wdata  <= req_wdata;
          r_size   <= req_size;
          r_write  <= req_write;
          r_signed <= req_signed;
          r_cnt    <= '0;
        end else if (req_valid) begin
          r_valid <= 1'b1;
          r_err   <= 1'b1;
          r_code  <= w_mis ? 2'b01 : 2'b10;
        end
      end else if (!ACKD_n) begin
        r_state <= IDLE;
        r_valid <= 1'b1;
        r_err   <= 1'b0;
        r_code  <= 2'b00;
        if (!r_write) r_rdata <= w_ext;
      end else if (w_to) begin
        r_state <= IDLE;
        r_valid <= 1'b1;
        r_err   <= 1'b1;
        r_code  <= 2'b11;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end
endmodule
